// File: rtl/vid_mode_track.sv
// Vertical video mode tracker: measures per-frame line timing from raw syncs and
// pixel-valid, confirms a stable mode before publishing it, and drops lock on loss.
module vid_mode_track #(
  parameter int          CW            = 16,
  parameter int          NCONFIRM      = 4,
  parameter int          NLOSS         = 3,
  parameter logic [31:0] TIMEOUT       = 32'd4_000_000,
  parameter bit          HS_ACTIVE_LOW = 1'b0,
  parameter bit          VS_ACTIVE_LOW = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_hsync,
  input  logic          i_vsync,
  input  logic          i_pv,
  output logic [CW-1:0] o_nlines,
  output logic [CW-1:0] o_vsstart,
  output logic [CW-1:0] o_vsend,
  output logic [CW-1:0] o_vtotal,
  output logic          o_locked,
  output logic          o_changed
);

  typedef enum logic [1:0] {SEARCH, CONFIRM, LOCKED, HOLD} state_t;

  typedef struct packed {
    logic [CW-1:0] nlines;
    logic [CW-1:0] vsstart;
    logic [CW-1:0] vsend;
    logic [CW-1:0] vtotal;
  } timing_t;

  localparam logic [CW-1:0] CNT_MAX = '1;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
    return (x == CNT_MAX) ? x : x + CW'(1);
  endfunction

  // Reset asserts immediately and releases on the second clock edge after i_reset_n rises.
  logic [1:0] rst_pipe;
  logic       rst_n;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rst_pipe <= 2'b00;
    else            rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_n = rst_pipe[1];

  logic hs, vs;
  assign hs = i_hsync ^ HS_ACTIVE_LOW;
  assign vs = i_vsync ^ VS_ACTIVE_LOW;

  logic hs_prev, line_start, p_flag, v_flag, last_p, frame_start;

  // The sample taken in the line-start clock already belongs to the new line.
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev    <= 1'b0;
      line_start <= 1'b0;
      p_flag     <= 1'b0;
      v_flag     <= 1'b0;
      last_p     <= 1'b0;
    end else begin
      hs_prev    <= hs;
      line_start <= hs & ~hs_prev;
      if (line_start) begin
        last_p <= p_flag;
        p_flag <= i_pv;
        v_flag <= vs;
      end else begin
        p_flag <= p_flag | i_pv;
        v_flag <= v_flag | vs;
      end
    end
  end

  assign frame_start = line_start & p_flag & ~last_p;

  logic [CW-1:0] cnt_total, cnt_p, cnt_shelf, cnt_v;
  logic          seen_v, first_frame, any_sat;
  timing_t       cand, cand_nx;
  logic          cand_valid, eval;

  assign any_sat = (cnt_total == CNT_MAX) | (cnt_p == CNT_MAX) |
                   (cnt_shelf == CNT_MAX) | (cnt_v == CNT_MAX);

  // The first active line closes the old frame, so it is not counted; the +1 terms restore it.
  assign cand_nx.nlines  = cnt_p + CW'(1);
  assign cand_nx.vsstart = cnt_p + CW'(1) + cnt_shelf;
  assign cand_nx.vsend   = cnt_p + CW'(1) + cnt_shelf + cnt_v;
  assign cand_nx.vtotal  = cnt_total + CW'(1);

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_total   <= '0;
      cnt_p       <= '0;
      cnt_shelf   <= '0;
      cnt_v       <= '0;
      seen_v      <= 1'b0;
      first_frame <= 1'b1;
      cand        <= '0;
      cand_valid  <= 1'b0;
      eval        <= 1'b0;
    end else begin
      eval <= frame_start;
      if (frame_start) begin
        cand        <= cand_nx;
        cand_valid  <= !first_frame && !any_sat && (cnt_v != '0);
        first_frame <= 1'b0;
        cnt_total   <= '0;
        cnt_p       <= '0;
        cnt_shelf   <= '0;
        cnt_v       <= '0;
        seen_v      <= 1'b0;
      end else if (line_start) begin
        cnt_total <= sat_inc(cnt_total);
        if (p_flag) cnt_p <= sat_inc(cnt_p);
        if (v_flag) begin
          cnt_v  <= sat_inc(cnt_v);
          seen_v <= 1'b1;
        end
        if (!p_flag && !v_flag && !seen_v) cnt_shelf <= sat_inc(cnt_shelf);
      end
    end
  end

  // A frame start in the same clock as expiry clears the counter and suppresses the timeout.
  logic [31:0] to_cnt;
  logic        to_expire;

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n)                  to_cnt <= '0;
    else if (frame_start)        to_cnt <= '0;
    else if (to_cnt != TIMEOUT)  to_cnt <= to_cnt + 32'd1;
  end

  assign to_expire = !frame_start && (to_cnt >= TIMEOUT - 32'd1);

  state_t     state, state_nx;
  timing_t    ref_q, ref_nx, out_q, out_nx;
  logic [3:0] match, match_nx, miss, miss_nx;
  logic       locked_q, locked_nx, changed_nx;
  logic       cand_eq;

  assign cand_eq = cand_valid && (cand == ref_q);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx   = state;
    ref_nx     = ref_q;
    out_nx     = out_q;
    match_nx   = match;
    miss_nx    = miss;
    locked_nx  = locked_q;
    changed_nx = 1'b0;
    if (to_expire) begin
      state_nx  = SEARCH;
      locked_nx = 1'b0;
      match_nx  = '0;
      miss_nx   = '0;
    end else if (eval) begin
      unique case (state)
        SEARCH: begin
          if (cand_valid) begin
            ref_nx   = cand;
            match_nx = 4'd1;
            state_nx = CONFIRM;
          end
        end
        CONFIRM: begin
          if (!cand_valid) begin
            state_nx = SEARCH;
            match_nx = '0;
          end else if (cand_eq) begin
            match_nx = match + 4'd1;
            if (int'(match) + 1 >= NCONFIRM) begin
              state_nx   = LOCKED;
              out_nx     = ref_q;
              locked_nx  = 1'b1;
              changed_nx = 1'b1;
              match_nx   = '0;
            end
          end else begin
            ref_nx   = cand;
            match_nx = 4'd1;
          end
        end
        LOCKED: begin
          if (!cand_eq) begin
            if (NLOSS <= 1) begin
              state_nx  = SEARCH;
              locked_nx = 1'b0;
              miss_nx   = '0;
            end else begin
              state_nx = HOLD;
              miss_nx  = 4'd1;
            end
          end
        end
        HOLD: begin
          if (cand_eq) begin
            state_nx = LOCKED;
            miss_nx  = '0;
          end else if (int'(miss) + 1 >= NLOSS) begin
            state_nx  = SEARCH;
            locked_nx = 1'b0;
            miss_nx   = '0;
            match_nx  = '0;
          end else begin
            miss_nx = miss + 4'd1;
          end
        end
        default: state_nx = SEARCH;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SEARCH;
      ref_q     <= '0;
      out_q     <= '0;
      match     <= '0;
      miss      <= '0;
      locked_q  <= 1'b0;
      o_changed <= 1'b0;
    end else begin
      state     <= state_nx;
      ref_q     <= ref_nx;
      out_q     <= out_nx;
      match     <= match_nx;
      miss      <= miss_nx;
      locked_q  <= locked_nx;
      o_changed <= changed_nx;
    end
  end

  assign o_nlines  = out_q.nlines;
  assign o_vsstart = out_q.vsstart;
  assign o_vsend   = out_q.vsend;
  assign o_vtotal  = out_q.vtotal;
  assign o_locked  = locked_q;

endmodule

// File: tb/tb_vid_mode_track.sv
// Bench for vid_mode_track: directed 1080p/720p scenarios plus randomized small modes,
// checked against a frame-level model of mode confirmation and loss.
module tb_vid_mode_track;

  localparam int          NCONF = 4;
  localparam int          NLOSS = 3;
  localparam logic [31:0] TO    = 32'd5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, hsync, vsync, pv;
  logic inv_hs, inv_vs;
  assign inv_hs = ~hsync;
  assign inv_vs = ~vsync;

  logic [15:0] nlines, vsstart, vsend, vtotal;
  logic        locked, changed;
  logic [15:0] i_nl, i_vss, i_vse, i_vt;
  logic        i_locked, i_changed;
  logic [7:0]  c_nl, c_vss, c_vse, c_vt;
  logic        c_locked, c_changed;

  vid_mode_track #(.CW(16), .NCONFIRM(NCONF), .NLOSS(NLOSS), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hsync), .i_vsync(vsync), .i_pv(pv),
    .o_nlines(nlines), .o_vsstart(vsstart), .o_vsend(vsend), .o_vtotal(vtotal),
    .o_locked(locked), .o_changed(changed));

  vid_mode_track #(.CW(16), .NCONFIRM(NCONF), .NLOSS(NLOSS), .TIMEOUT(TO),
                   .HS_ACTIVE_LOW(1'b1), .VS_ACTIVE_LOW(1'b1)) dut_inv (
    .i_clk(clk), .i_reset_n(rst_n), .i_hsync(inv_hs), .i_vsync(inv_vs), .i_pv(pv),
    .o_nlines(i_nl), .o_vsstart(i_vss), .o_vsend(i_vse), .o_vtotal(i_vt),
    .o_locked(i_locked), .o_changed(i_changed));

  vid_mode_track #(.CW(8), .NCONFIRM(NCONF), .NLOSS(NLOSS), .TIMEOUT(TO)) dut_cw8 (
    .i_clk(clk), .i_reset_n(rst_n), .i_hsync(hsync), .i_vsync(vsync), .i_pv(pv),
    .o_nlines(c_nl), .o_vsstart(c_vss), .o_vsend(c_vse), .o_vtotal(c_vt),
    .o_locked(c_locked), .o_changed(c_changed));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nchg   = 0;
  int inv_nchg = 0;
  bit c8_ever_locked = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (changed === 1'b1)   nchg <= nchg + 1;
    if (i_changed === 1'b1) inv_nchg <= inv_nchg + 1;
    if (c_locked === 1'b1)  c8_ever_locked <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  typedef struct { int a; int f; int s; int b; } geom_t;
  typedef struct packed { logic [15:0] n; logic [15:0] vs; logic [15:0] ve; logic [15:0] vt; } tim_t;

  // Frame-level model: a candidate describes the previous complete frame's geometry.
  bit    have_prev;
  geom_t prev;
  bit    m_locked;
  tim_t  m_pub, m_smode;
  int    m_streak, m_miss, m_chg, chg_base, fidx, fs_cyc, last_hs_cyc;

  function automatic tim_t geom2tim(input geom_t g);
    tim_t t;
    t.n  = 16'(g.a);
    t.vs = 16'(g.a + g.f);
    t.ve = 16'(g.a + g.f + g.s);
    t.vt = 16'(g.a + g.f + g.s + g.b);
    return t;
  endfunction

  task automatic model_reset();
    have_prev = 1'b0;
    m_locked  = 1'b0;
    m_pub     = '0;
    m_smode   = '0;
    m_streak  = 0;
    m_miss    = 0;
    m_chg     = 0;
    chg_base  = nchg;
  endtask

  task automatic model_eval(input bit valid, input tim_t c);
    if (m_locked) begin
      if (valid && c == m_pub) m_miss = 0;
      else begin
        m_miss++;
        if (m_miss >= NLOSS) begin
          m_locked = 1'b0;
          m_miss   = 0;
          m_streak = 0;
        end
      end
    end else begin
      if (!valid) m_streak = 0;
      else if (m_streak > 0 && c == m_smode) m_streak++;
      else begin
        m_streak = 1;
        m_smode  = c;
      end
      if (m_streak >= NCONF) begin
        m_locked = 1'b1;
        m_pub    = c;
        m_chg++;
        m_streak = 0;
      end
    end
  endtask

  task automatic drive_line(input bit p, input bit v, input int extra);
    @(negedge clk);
    hsync = 1'b1; pv = 1'b0; vsync = 1'b0;
    last_hs_cyc = cyc;
    @(negedge clk);
    hsync = 1'b0; pv = p; vsync = v;
    repeat (extra) @(negedge clk);
  endtask

  task automatic run_frame(input geom_t g, input bit jitter);
    int   total;
    bit   valid;
    tim_t c;
    valid = have_prev && prev.s > 0 && (prev.a - 1 + prev.f + prev.s + prev.b) < 65535;
    c     = geom2tim(prev);
    model_eval(valid, c);
    prev      = g;
    have_prev = 1'b1;
    total = g.a + g.f + g.s + g.b;
    for (int k = 0; k < total; k++) begin
      drive_line(k < g.a, (k >= g.a + g.f) && (k < g.a + g.f + g.s),
                 jitter ? int'($urandom_range(0, 1)) : 0);
      if (k == 1) fs_cyc = last_hs_cyc;
    end
    fidx++;
    check($sformatf("f%0d_locked", fidx),  32'(locked),  32'(m_locked));
    check($sformatf("f%0d_nlines", fidx),  32'(nlines),  32'(m_pub.n));
    check($sformatf("f%0d_vsstart", fidx), 32'(vsstart), 32'(m_pub.vs));
    check($sformatf("f%0d_vsend", fidx),   32'(vsend),   32'(m_pub.ve));
    check($sformatf("f%0d_vtotal", fidx),  32'(vtotal),  32'(m_pub.vt));
    check($sformatf("f%0d_changes", fidx), 32'(nchg - chg_base), 32'(m_chg));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed still running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    geom_t g1080, g1124, g720, g, gx;
    int reps;
    g1080 = '{a: 1080, f: 4, s: 5, b: 36};
    g1124 = '{a: 1080, f: 4, s: 5, b: 35};
    g720  = '{a: 720,  f: 5, s: 5, b: 20};
    fidx = 0;
    hsync = 1'b0; vsync = 1'b0; pv = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_locked",  32'(locked),  32'd0);
    check("rst_changed", 32'(changed), 32'd0);
    check("rst_nlines",  32'(nlines),  32'd0);
    check("rst_vtotal",  32'(vtotal),  32'd0);
    check("rst_inv_locked", 32'(i_locked), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();

    // 1080p acquisition: lock after the fifth frame start
    repeat (5) run_frame(g1080, 1'b0);
    check("lock1080_locked",  32'(locked),  32'd1);
    check("lock1080_nlines",  32'(nlines),  32'd1080);
    check("lock1080_vsstart", 32'(vsstart), 32'd1084);
    check("lock1080_vsend",   32'(vsend),   32'd1089);
    check("lock1080_vtotal",  32'(vtotal),  32'd1125);
    check("lock1080_pulses",  32'(nchg - chg_base), 32'd1);
    check("inv_locked",  32'(i_locked), 32'd1);
    check("inv_nlines",  32'(i_nl),  32'd1080);
    check("inv_vsstart", 32'(i_vss), 32'd1084);
    check("inv_vsend",   32'(i_vse), 32'd1089);
    check("inv_vtotal",  32'(i_vt),  32'd1125);
    check("inv_pulses",  32'(inv_nchg), 32'd1);

    // One short frame is tolerated, three in a row drop lock
    run_frame(g1124, 1'b0);
    run_frame(g1080, 1'b0);
    check("glitch1_locked", 32'(locked), 32'd1);
    check("glitch1_vtotal", 32'(vtotal), 32'd1125);
    repeat (3) run_frame(g1124, 1'b0);
    run_frame(g720, 1'b0);
    check("loss_locked", 32'(locked), 32'd0);
    check("loss_vtotal", 32'(vtotal), 32'd1125);
    check("loss_nlines", 32'(nlines), 32'd1080);

    // Relock on 720p
    repeat (4) run_frame(g720, 1'b0);
    check("lock720_locked",  32'(locked),  32'd1);
    check("lock720_nlines",  32'(nlines),  32'd720);
    check("lock720_vsstart", 32'(vsstart), 32'd725);
    check("lock720_vsend",   32'(vsend),   32'd730);
    check("lock720_vtotal",  32'(vtotal),  32'd750);
    check("lock720_pulses",  32'(nchg - chg_base), 32'd2);
    check("cw8_never_locked", 32'(c8_ever_locked), 32'd0);

    // Syncs stop: lock drops exactly TIMEOUT clocks after the last frame start
    while (cyc < fs_cyc + int'(TO) + 1) @(negedge clk);
    check("timeout_before", 32'(locked), 32'd1);
    @(negedge clk);
    check("timeout_after",  32'(locked), 32'd0);
    check("timeout_hold_nlines", 32'(nlines), 32'd720);

    // Asynchronous reset takes effect without a clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_nlines", 32'(nlines), 32'd0);
    check("async_rst_vtotal", 32'(vtotal), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();

    // Randomized small modes with occasional glitch frames and missing vsync
    for (int seg = 0; seg < 12; seg++) begin
      g.a = int'($urandom_range(6, 30));
      g.f = int'($urandom_range(1, 4));
      g.s = int'($urandom_range(0, 3));
      g.b = int'($urandom_range(1, 8));
      reps = int'($urandom_range(1, 7));
      for (int r = 0; r < reps; r++) begin
        gx = g;
        if ($urandom_range(0, 5) == 0) gx.b = g.b + 1;
        run_frame(gx, 1'b1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_mode_track.md
VID_MODE_TRACK -- requirements
Module: vid_mode_track

Interface
REQ-001 SHALL have parameter CW, default 16, width of every line counter and timing output.
REQ-002 SHALL have parameter NCONFIRM, default 4, consecutive identical frames needed to lock (2..15).
REQ-003 SHALL have parameter NLOSS, default 3, consecutive bad frames needed to drop lock (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 32'd4_000_000, clocks without a frame start before lock is dropped.
REQ-005 SHALL have parameters HS_ACTIVE_LOW and VS_ACTIVE_LOW, default 0, inverting the respective sync input before use.
REQ-006 i_clk  input  1  sole clock; all logic on rising edge.
REQ-007 i_reset_n  input  1  asynchronous, active-low reset.
REQ-008 i_hsync, i_vsync, i_pv  input  1 each  raw syncs and pixel-valid, synchronous to i_clk.
REQ-009 o_nlines, o_vsstart, o_vsend, o_vtotal  output  CW each  locked vertical timing (active lines, sync start, sync end, total lines).
REQ-010 o_locked  output  1  timing outputs are confirmed and current.
REQ-011 o_changed  output  1  one-clock pulse when a new mode is published.

Function
REQ-012 Line start SHALL be a one-clock pulse, registered, on each rising edge of the polarity-corrected hsync; latency 1 clock after the edge.
REQ-013 Between line starts: flag P set if i_pv seen, flag V set if corrected vsync seen; at line start both SHALL move to the last-line history and clear.
REQ-014 Frame start SHALL pulse with a line start when the completed line had P and the line before it did not.
REQ-015 Per frame, saturating CW-bit counters SHALL accumulate: total lines, lines with P, non-P non-V lines before the first V line (shelf), lines with V.
REQ-016 At frame start, candidate SHALL be: nlines=P count+1, vsstart=nlines+shelf, vsend=vsstart+V count, vtotal=total+1, all modulo 2^CW; counters clear the same clock.
REQ-017 Candidate SHALL be invalid if any counter saturated, V count is 0, or it is the first frame start after reset (partial frame).
REQ-018 Tracking FSM states: SEARCH, CONFIRM, LOCKED, HOLD; evaluated one clock after frame start.
REQ-019 SEARCH: valid candidate -> store as reference, match=1, CONFIRM; invalid -> stay.
REQ-020 CONFIRM: candidate equals reference -> match+1; match reaching NCONFIRM -> LOCKED; unequal valid -> replace reference, match=1; invalid -> SEARCH.
REQ-021 Entering LOCKED from CONFIRM SHALL load outputs from reference, set o_locked and pulse o_changed in the same clock.
REQ-022 LOCKED: equal -> stay; unequal or invalid -> HOLD, miss=1, outputs unchanged, o_locked stays 1.
REQ-023 HOLD: equal -> LOCKED, miss=0; otherwise miss+1; miss reaching NLOSS -> SEARCH, o_locked=0.
REQ-024 A TIMEOUT counter SHALL clear on each frame start, saturate at TIMEOUT, and on reaching it force SEARCH and o_locked=0 from any state.
REQ-025 Timing outputs SHALL hold last published values when lock drops; only REQ-021 updates them.
REQ-026 Timeout and frame start in the same clock: frame start wins, counter clears.

Reset
REQ-027 Reset SHALL force FSM=SEARCH, all counters, flags, reference, and outputs to 0, o_locked=0, o_changed=0, first-frame flag set.
REQ-028 Reset assertion mid-frame or mid-lock SHALL take effect immediately; release SHALL be synchronised to i_clk.

Verification
REQ-029 1080p stream (1080 active, 4 front, 5 sync, 36 back) -> after 5th frame start: o_nlines=1080, o_vsstart=1084, o_vsend=1089, o_vtotal=1125, o_locked=1, one o_changed pulse.
REQ-030 Locked 1080p, then one 1124-line frame -> o_locked stays 1, outputs unchanged; 3 such frames -> o_locked=0, outputs still 1080p values.
REQ-031 Locked 1080p, syncs stopped -> o_locked=0 exactly TIMEOUT clocks after last frame start.
REQ-032 Switch 1080p to 720p (720 active, 5, 5, 20) -> relock after NCONFIRM valid 720p frames: 720/725/730/750, single o_changed.
REQ-033 HS_ACTIVE_LOW=VS_ACTIVE_LOW=1 with inverted 1080p syncs -> identical results to REQ-029.
REQ-034 CW=8 with 1080p -> counters saturate, every candidate invalid, o_locked never asserts.
